// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding / hazard unit of the RV32I core.
package fwd_scoreboard_pkg;

    localparam int DEF_NUM_FWD_STAGES = 2;
    localparam int DEF_SEL_W          = $clog2(DEF_NUM_FWD_STAGES + 1);

    typedef logic [DEF_SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t   FWD_SEL_NONE = {DEF_SEL_W{1'b0}};
    localparam logic [4:0] REG_X0       = 5'd0;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle. Optional FWD_SCOREBOARD_PERF_EN adds the stall
// statistics counters.
interface fwd_scoreboard_if #(
    parameter int NUM_FWD_STAGES  = 2,
    parameter int NUM_SRC         = 2,
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stage_rd;
    logic [NUM_FWD_STAGES-1:0]            stage_wen;
    logic [NUM_SRC*REG_ADDR_W-1:0]        ex_rs;
    logic [NUM_SRC*SEL_W-1:0]             ex_fwd_sel;
    logic [NUM_SRC*REG_ADDR_W-1:0]        id_rs;
    logic [NUM_SRC-1:0]                   id_rs_used;
    logic [REG_ADDR_W-1:0]                id_rd;
    logic                                 id_wen;
    logic [NUM_SRC-1:0]                   id_bypass_sel;
    logic [REG_ADDR_W-1:0]                idex_rd;
    logic                                 idex_wen;
    logic                                 idex_is_load;
    logic                                 mc_issue_valid;
    logic [REG_ADDR_W-1:0]                mc_issue_rd;
    logic                                 mc_issue_ready;
    logic                                 mc_done_valid;
    logic [REG_ADDR_W-1:0]                mc_done_rd;
    logic                                 stall;
    logic [CNT_W-1:0]                     pending_cnt;
    logic                                 mc_err;
`ifdef FWD_SCOREBOARD_PERF_EN
    logic [31:0]                          stall_loaduse_cnt;
    logic [31:0]                          stall_sb_cnt;

    modport master (
        output stage_rd, stage_wen, ex_rs, id_rs, id_rs_used, id_rd, id_wen,
               idex_rd, idex_wen, idex_is_load, mc_issue_valid, mc_issue_rd,
               mc_done_valid, mc_done_rd,
        input  ex_fwd_sel, id_bypass_sel, mc_issue_ready, stall, pending_cnt,
               mc_err, stall_loaduse_cnt, stall_sb_cnt
    );

    modport slave (
        input  stage_rd, stage_wen, ex_rs, id_rs, id_rs_used, id_rd, id_wen,
               idex_rd, idex_wen, idex_is_load, mc_issue_valid, mc_issue_rd,
               mc_done_valid, mc_done_rd,
        output ex_fwd_sel, id_bypass_sel, mc_issue_ready, stall, pending_cnt,
               mc_err, stall_loaduse_cnt, stall_sb_cnt
    );
`else
    modport master (
        output stage_rd, stage_wen, ex_rs, id_rs, id_rs_used, id_rd, id_wen,
               idex_rd, idex_wen, idex_is_load, mc_issue_valid, mc_issue_rd,
               mc_done_valid, mc_done_rd,
        input  ex_fwd_sel, id_bypass_sel, mc_issue_ready, stall, pending_cnt,
               mc_err
    );

    modport slave (
        input  stage_rd, stage_wen, ex_rs, id_rs, id_rs_used, id_rd, id_wen,
               idex_rd, idex_wen, idex_is_load, mc_issue_valid, mc_issue_rd,
               mc_done_valid, mc_done_rd,
        output ex_fwd_sel, id_bypass_sel, mc_issue_ready, stall, pending_cnt,
               mc_err
    );
`endif

endinterface

// File: rtl/fwd_prio_match.sv
// Priority encoder over producer stages: returns k+1 for the youngest stage k
// that writes a non-x0 register equal to rs, or 0 when none does.
module fwd_prio_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd,
    input  logic [NUM_STAGES-1:0]            stage_wen,
    input  logic [REG_ADDR_W-1:0]            rs,
    output logic [SEL_W-1:0]                 sel
);

    logic [NUM_STAGES-1:0] hit_s;

    // Per-stage match: writes enabled, not x0, same register.
    always_comb begin
        hit_s = {NUM_STAGES{1'b0}};
        for (int k = 0; k < NUM_STAGES; k++) begin
            hit_s[k] = stage_wen[k]
                && (stage_rd[k*REG_ADDR_W +: REG_ADDR_W] != REG_ADDR_W'(REG_X0))
                && (stage_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs);
        end
    end

    // Scan oldest to youngest so the youngest hit overwrites the rest.
    always_comb begin
        sel = SEL_W'(FWD_SEL_NONE);
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            sel = hit_s[k] ? SEL_W'(k + 1) : sel;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding, ID bypass, load-use and multi-cycle scoreboard hazard unit.
// Optional FWD_SCOREBOARD_PERF_EN adds saturating stall-cause counters.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_FWD_STAGES  = 2,
    parameter int NUM_SRC         = 2,
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk,
    input  logic           rst,
    fwd_scoreboard_if.slave sb
);

    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int NREGS = 1 << REG_ADDR_W;
    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [REG_ADDR_W-1:0] X0      = REG_ADDR_W'(REG_X0);

    logic [NREGS-1:1]             pending_r;
    logic [NREGS-1:0]             pending_s;
    logic [NREGS-1:0]             pending_nxt_s;
    logic [CNT_W-1:0]             cnt_r;
    logic [CNT_W-1:0]             cnt_nxt_s;
    logic                         err_r;
    logic                         loaduse_s;
    logic                         sb_haz_s;
    logic                         stall_s;
    logic                         ready_s;
    logic                         issue_acc_s;
    logic                         done_ok_s;
    logic                         done_bad_s;
    logic [NUM_SRC*SEL_W-1:0]     ex_fwd_sel_s;
    logic [NUM_SRC-1:0]           id_bypass_sel_s;

    assign pending_s = {pending_r, 1'b0};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_prio_match #(
            .NUM_STAGES (NUM_FWD_STAGES),
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (SEL_W)
        ) u_ex_match (
            .stage_rd  (sb.stage_rd),
            .stage_wen (sb.stage_wen),
            .rs        (sb.ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .sel       (ex_fwd_sel_s[i*SEL_W +: SEL_W])
        );

        // Only the WB stage can bypass around the regfile read in ID.
        fwd_prio_match #(
            .NUM_STAGES (1),
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (1)
        ) u_id_match (
            .stage_rd  (sb.stage_rd[(NUM_FWD_STAGES-1)*REG_ADDR_W +: REG_ADDR_W]),
            .stage_wen (sb.stage_wen[NUM_FWD_STAGES-1]),
            .rs        (sb.id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .sel       (id_bypass_sel_s[i])
        );
    end

    // Hazard detection: load-use on the EX producer, RAW/WAW on pending registers.
    always_comb begin
        loaduse_s = 1'b0;
        sb_haz_s  = sb.id_wen && pending_s[sb.id_rd];
        for (int i = 0; i < NUM_SRC; i++) begin
            loaduse_s = loaduse_s
                || (sb.id_rs_used[i]
                    && (sb.id_rs[i*REG_ADDR_W +: REG_ADDR_W] != X0)
                    && sb.idex_wen && sb.idex_is_load
                    && (sb.idex_rd == sb.id_rs[i*REG_ADDR_W +: REG_ADDR_W]));
            sb_haz_s = sb_haz_s
                || (sb.id_rs_used[i] && pending_s[sb.id_rs[i*REG_ADDR_W +: REG_ADDR_W]]);
        end
        stall_s = loaduse_s || sb_haz_s;
    end

    assign ready_s     = !stall_s && (cnt_r < MAX_CNT) && !pending_s[sb.mc_issue_rd];
    assign issue_acc_s = sb.mc_issue_valid && ready_s && (sb.mc_issue_rd != X0);
    assign done_ok_s   = sb.mc_done_valid && (sb.mc_done_rd != X0) && pending_s[sb.mc_done_rd];
    assign done_bad_s  = sb.mc_done_valid && !done_ok_s;

    // Next scoreboard contents; issue and done never target the same register.
    always_comb begin
        pending_nxt_s = pending_s;
        if (issue_acc_s) begin
            pending_nxt_s[sb.mc_issue_rd] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (done_ok_s) begin
            pending_nxt_s[sb.mc_done_rd] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Outstanding count follows the set/clear pair.
    always_comb begin
        case ({issue_acc_s, done_ok_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Scoreboard state and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
            cnt_r     <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s[NREGS-1:1];
            cnt_r     <= cnt_nxt_s;
            err_r     <= err_r || done_bad_s;
        end
    end

    assign sb.ex_fwd_sel     = ex_fwd_sel_s;
    assign sb.id_bypass_sel  = id_bypass_sel_s;
    assign sb.stall          = stall_s;
    assign sb.mc_issue_ready = ready_s;
    assign sb.pending_cnt    = cnt_r;
    assign sb.mc_err         = err_r;

`ifdef FWD_SCOREBOARD_PERF_EN
    logic [31:0] lu_cnt_r;
    logic [31:0] sbh_cnt_r;

    // Stall-cause statistics; load-use wins when both causes coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt_r  <= 32'd0;
            sbh_cnt_r <= 32'd0;
        end else begin
            if (loaduse_s && (lu_cnt_r != 32'hFFFF_FFFF)) begin
                lu_cnt_r <= lu_cnt_r + 32'd1;
            end else begin
                lu_cnt_r <= lu_cnt_r;
            end
            if (!loaduse_s && sb_haz_s && (sbh_cnt_r != 32'hFFFF_FFFF)) begin
                sbh_cnt_r <= sbh_cnt_r + 32'd1;
            end else begin
                sbh_cnt_r <= sbh_cnt_r;
            end
        end
    end

    assign sb.stall_loaduse_cnt = lu_cnt_r;
    assign sb.stall_sb_cnt      = sbh_cnt_r;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized
// traffic against a register-array reference model.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.NUM_FWD_STAGES(2), .NUM_SRC(2), .REG_ADDR_W(5), .MAX_OUTSTANDING(4)) bus ();

    fwd_scoreboard #(.NUM_FWD_STAGES(2), .NUM_SRC(2), .REG_ADDR_W(5), .MAX_OUTSTANDING(4)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: set of in-flight destinations plus sticky error.
    bit pend[32];
    int cnt;
    bit err;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        cnt = 0;
        err = 1'b0;
    endtask

    function automatic logic [1:0] m_sel(int i);
        logic [4:0] rs;
        rs = bus.ex_rs[i*5 +: 5];
        for (int k = 0; k < 2; k++)
            if (bus.stage_wen[k] && bus.stage_rd[k*5 +: 5] != 5'd0 && bus.stage_rd[k*5 +: 5] == rs)
                return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic logic m_byp(int i);
        return bus.stage_wen[1] && bus.stage_rd[9:5] != 5'd0 && bus.stage_rd[9:5] == bus.id_rs[i*5 +: 5];
    endfunction

    function automatic logic m_stall();
        logic [4:0] rs;
        if (bus.id_wen && pend[bus.id_rd]) return 1'b1;
        for (int i = 0; i < 2; i++) begin
            rs = bus.id_rs[i*5 +: 5];
            if (bus.id_rs_used[i] && pend[rs]) return 1'b1;
            if (bus.id_rs_used[i] && rs != 5'd0 && bus.idex_wen && bus.idex_is_load && bus.idex_rd == rs)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_ready();
        return !m_stall() && cnt < 4 && !pend[bus.mc_issue_rd];
    endfunction

    task automatic clear_inputs();
        bus.stage_rd = '0; bus.stage_wen = '0; bus.ex_rs = '0;
        bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0; bus.id_wen = 1'b0;
        bus.idex_rd = '0; bus.idex_wen = 1'b0; bus.idex_is_load = 1'b0;
        bus.mc_issue_valid = 1'b0; bus.mc_issue_rd = '0;
        bus.mc_done_valid = 1'b0; bus.mc_done_rd = '0;
    endtask

    // Advance one clock (inputs driven at negedge) and update the model.
    task automatic tick();
        bit acc, dok, dbad;
        int ird, drd;
        ird  = int'(bus.mc_issue_rd);
        drd  = int'(bus.mc_done_rd);
        acc  = bus.mc_issue_valid && m_ready() && ird != 0;
        dok  = bus.mc_done_valid && drd != 0 && pend[drd];
        dbad = bus.mc_done_valid && !dok;
        @(posedge clk);
        if (rst) begin
            if (acc) begin pend[ird] = 1'b1; cnt++; end
            if (dok) begin pend[drd] = 1'b0; cnt--; end
            if (dbad) err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        chk_cnt++; if (bus.pending_cnt !== 3'd0) $display("FAIL reset_cnt: got %0d exp 0", bus.pending_cnt); else pass_cnt++;
        chk_cnt++; if (bus.mc_err !== 1'b0) $display("FAIL reset_err: got %0b exp 0", bus.mc_err); else pass_cnt++;
        chk_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %0b exp 0", bus.stall); else pass_cnt++;
        chk_cnt++; if (bus.mc_issue_ready !== 1'b1) $display("FAIL reset_ready: got %0b exp 1", bus.mc_issue_ready); else pass_cnt++;
    endtask

    task automatic test_ex_fwd();
        clear_inputs();
        bus.stage_rd = {5'd5, 5'd5}; bus.stage_wen = 2'b11; bus.ex_rs = {5'd0, 5'd5};
        #1;
        chk_cnt++; if (bus.ex_fwd_sel[1:0] !== 2'd1) $display("FAIL fwd_youngest: got %0d exp 1", bus.ex_fwd_sel[1:0]); else pass_cnt++;
        bus.stage_wen = 2'b10;
        #1;
        chk_cnt++; if (bus.ex_fwd_sel[1:0] !== 2'd2) $display("FAIL fwd_wb_only: got %0d exp 2", bus.ex_fwd_sel[1:0]); else pass_cnt++;
        bus.ex_rs = {5'd5, 5'd6};
        #1;
        chk_cnt++; if (bus.ex_fwd_sel !== 4'b1000) $display("FAIL fwd_src1: got %b exp 1000", bus.ex_fwd_sel); else pass_cnt++;
        bus.stage_rd = '0; bus.stage_wen = 2'b11; bus.ex_rs = '0;
        #1;
        chk_cnt++; if (bus.ex_fwd_sel !== 4'b0000) $display("FAIL fwd_x0: got %b exp 0000", bus.ex_fwd_sel); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_id_bypass();
        clear_inputs();
        bus.stage_rd = {5'd7, 5'd0}; bus.stage_wen = 2'b10; bus.id_rs = {5'd7, 5'd0};
        #1;
        chk_cnt++; if (bus.id_bypass_sel !== 2'b10) $display("FAIL bypass_wb: got %b exp 10", bus.id_bypass_sel); else pass_cnt++;
        bus.stage_rd = {5'd9, 5'd7}; bus.stage_wen = 2'b01;
        #1;
        chk_cnt++; if (bus.id_bypass_sel !== 2'b00) $display("FAIL bypass_exmem_only: got %b exp 00", bus.id_bypass_sel); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_loaduse();
        clear_inputs();
        bus.idex_rd = 5'd3; bus.idex_wen = 1'b1; bus.idex_is_load = 1'b1;
        bus.id_rs = {5'd0, 5'd3}; bus.id_rs_used = 2'b01;
        #1;
        chk_cnt++; if (bus.stall !== 1'b1) $display("FAIL loaduse_stall: got %0b exp 1", bus.stall); else pass_cnt++;
        chk_cnt++; if (bus.mc_issue_ready !== 1'b0) $display("FAIL loaduse_ready: got %0b exp 0", bus.mc_issue_ready); else pass_cnt++;
        bus.id_rs_used = 2'b00;
        #1;
        chk_cnt++; if (bus.stall !== 1'b0) $display("FAIL loaduse_unused: got %0b exp 0", bus.stall); else pass_cnt++;
        bus.id_rs_used = 2'b01; bus.idex_is_load = 1'b0;
        #1;
        chk_cnt++; if (bus.stall !== 1'b0) $display("FAIL loaduse_notload: got %0b exp 0", bus.stall); else pass_cnt++;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        bus.mc_issue_valid = 1'b1; bus.mc_issue_rd = 5'd10;
        #1;
        chk_cnt++; if (bus.mc_issue_ready !== 1'b1) $display("FAIL sb_issue_ready: got %0b exp 1", bus.mc_issue_ready); else pass_cnt++;
        tick();
        bus.mc_issue_valid = 1'b0;
        bus.id_rs = {5'd0, 5'd10}; bus.id_rs_used = 2'b01;
        #1;
        chk_cnt++; if (bus.stall !== 1'b1) $display("FAIL sb_raw_stall: got %0b exp 1", bus.stall); else pass_cnt++;
        chk_cnt++; if (bus.pending_cnt !== 3'd1) $display("FAIL sb_cnt_one: got %0d exp 1", bus.pending_cnt); else pass_cnt++;
        bus.mc_done_valid = 1'b1; bus.mc_done_rd = 5'd10;
        #1;
        chk_cnt++; if (bus.stall !== 1'b1) $display("FAIL sb_stall_done_cycle: got %0b exp 1", bus.stall); else pass_cnt++;
        tick();
        bus.mc_done_valid = 1'b0;
        #1;
        chk_cnt++; if (bus.stall !== 1'b0) $display("FAIL sb_stall_after_done: got %0b exp 0", bus.stall); else pass_cnt++;
        chk_cnt++; if (bus.pending_cnt !== 3'd0) $display("FAIL sb_cnt_zero: got %0d exp 0", bus.pending_cnt); else pass_cnt++;
        chk_cnt++; if (bus.mc_err !== 1'b0) $display("FAIL sb_no_err: got %0b exp 0", bus.mc_err); else pass_cnt++;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_full();
        clear_inputs();
        bus.mc_issue_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            bus.mc_issue_rd = 5'(r);
            tick();
        end
        bus.mc_issue_rd = 5'd5;
        #1;
        chk_cnt++; if (bus.pending_cnt !== 3'd4) $display("FAIL full_cnt: got %0d exp 4", bus.pending_cnt); else pass_cnt++;
        chk_cnt++; if (bus.mc_issue_ready !== 1'b0) $display("FAIL full_ready: got %0b exp 0", bus.mc_issue_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.pending_cnt !== 3'd4) $display("FAIL full_no_fifth: got %0d exp 4", bus.pending_cnt); else pass_cnt++;
        bus.mc_issue_valid = 1'b0; bus.mc_done_valid = 1'b1; bus.mc_done_rd = 5'd4;
        tick();
        bus.mc_done_valid = 1'b0; bus.mc_issue_valid = 1'b1; bus.mc_issue_rd = 5'd1;
        #1;
        chk_cnt++; if (bus.mc_issue_ready !== 1'b0) $display("FAIL reissue_ready: got %0b exp 0", bus.mc_issue_ready); else pass_cnt++;
        bus.mc_issue_valid = 1'b0; bus.id_wen = 1'b1; bus.id_rd = 5'd2;
        #1;
        chk_cnt++; if (bus.stall !== 1'b1) $display("FAIL waw_stall: got %0b exp 1", bus.stall); else pass_cnt++;
        bus.id_wen = 1'b0; bus.mc_done_valid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            bus.mc_done_rd = 5'(r);
            tick();
        end
        bus.mc_done_valid = 1'b0;
        #1;
        chk_cnt++; if (bus.pending_cnt !== 3'd0) $display("FAIL full_drain: got %0d exp 0", bus.pending_cnt); else pass_cnt++;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_err_reset();
        clear_inputs();
        bus.mc_issue_valid = 1'b1; bus.mc_issue_rd = 5'd9;
        tick();
        bus.mc_issue_valid = 1'b0; bus.mc_done_valid = 1'b1; bus.mc_done_rd = 5'd12;
        tick();
        bus.mc_done_valid = 1'b0;
        tick();
        bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
        #1;
        chk_cnt++; if (bus.mc_err !== 1'b1) $display("FAIL err_sticky: got %0b exp 1", bus.mc_err); else pass_cnt++;
        chk_cnt++; if (bus.pending_cnt !== 3'd1) $display("FAIL err_cnt_kept: got %0d exp 1", bus.pending_cnt); else pass_cnt++;
        chk_cnt++; if (bus.stall !== 1'b1) $display("FAIL err_stall: got %0b exp 1", bus.stall); else pass_cnt++;
        rst = 1'b0;
        #1;
        model_reset();
        chk_cnt++; if (bus.pending_cnt !== 3'd0) $display("FAIL midrst_cnt: got %0d exp 0", bus.pending_cnt); else pass_cnt++;
        chk_cnt++; if (bus.mc_err !== 1'b0) $display("FAIL midrst_err: got %0b exp 0", bus.mc_err); else pass_cnt++;
        chk_cnt++; if (bus.stall !== 1'b0) $display("FAIL midrst_stall: got %0b exp 0", bus.stall); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_random();
        int q[$];
        for (int c = 0; c < 400; c++) begin
            bus.stage_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.stage_wen      = 2'($urandom_range(0, 3));
            bus.ex_rs          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.id_rs          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.id_rs_used     = 2'($urandom_range(0, 3));
            bus.id_rd          = 5'($urandom_range(0, 7));
            bus.id_wen         = ($urandom_range(0, 3) == 0);
            bus.idex_rd        = 5'($urandom_range(0, 7));
            bus.idex_wen       = 1'($urandom_range(0, 1));
            bus.idex_is_load   = ($urandom_range(0, 2) == 0);
            bus.mc_issue_valid = 1'($urandom_range(0, 1));
            bus.mc_issue_rd    = 5'($urandom_range(0, 7));
            q.delete();
            for (int r = 1; r < 32; r++) if (pend[r]) q.push_back(r);
            bus.mc_done_valid  = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 19) != 0)
                bus.mc_done_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.mc_done_rd = 5'($urandom_range(0, 7));
            if (c == 200) rst = 1'b0;
            if (c == 201) rst = 1'b1;
            if (!rst) model_reset();
            #1;
            for (int i = 0; i < 2; i++) begin
                chk_cnt++; if (bus.ex_fwd_sel[i*2 +: 2] !== m_sel(i)) $display("FAIL rand_fwd[%0d] cyc %0d: got %0d exp %0d", i, c, bus.ex_fwd_sel[i*2 +: 2], m_sel(i)); else pass_cnt++;
                chk_cnt++; if (bus.id_bypass_sel[i] !== m_byp(i)) $display("FAIL rand_byp[%0d] cyc %0d: got %0b exp %0b", i, c, bus.id_bypass_sel[i], m_byp(i)); else pass_cnt++;
            end
            chk_cnt++; if (bus.stall !== m_stall()) $display("FAIL rand_stall cyc %0d: got %0b exp %0b", c, bus.stall, m_stall()); else pass_cnt++;
            chk_cnt++; if (bus.mc_issue_ready !== m_ready()) $display("FAIL rand_ready cyc %0d: got %0b exp %0b", c, bus.mc_issue_ready, m_ready()); else pass_cnt++;
            chk_cnt++; if (int'(bus.pending_cnt) != cnt) $display("FAIL rand_cnt cyc %0d: got %0d exp %0d", c, bus.pending_cnt, cnt); else pass_cnt++;
            chk_cnt++; if (bus.mc_err !== err) $display("FAIL rand_err cyc %0d: got %0b exp %0b", c, bus.mc_err, err); else pass_cnt++;
            tick();
        end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_ex_fwd();
        test_id_bypass();
        test_loaduse();
        test_scoreboard();
        test_full();
        test_err_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined RV32I core.
- Generalises fixed two-stage EX/MEM, MEM/WB forwarding to NUM_FWD_STAGES producer stages and NUM_SRC source operands.
- Adds ID-stage write-back bypass, load-use stall detection and a registered scoreboard for an out-of-pipeline multi-cycle unit (mul/div).
- Sits beside the ID/EX/MEM/WB registers; drives the EX operand muxes, the ID regfile-bypass muxes and the pipeline stall.

Parameters:
- NUM_FWD_STAGES, 2: producer stages after EX; index 0 is the youngest (EX/MEM), index NUM_FWD_STAGES-1 is WB.
- NUM_SRC, 2: source operands per instruction.
- REG_ADDR_W, 5: register index width.
- MAX_OUTSTANDING, 4: maximum in-flight multi-cycle writes.
- Derived SEL_W = $clog2(NUM_FWD_STAGES+1).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- stage_rd  in  NUM_FWD_STAGES*REG_ADDR_W  rd per producer stage.
- stage_wen  in  NUM_FWD_STAGES  load_regfile per stage.
- ex_rs  in  NUM_SRC*REG_ADDR_W  sources of the instruction in EX.
- ex_fwd_sel  out  NUM_SRC*SEL_W  0 = ID/EX value; k = stage k-1.
- id_rs  in  NUM_SRC*REG_ADDR_W  sources of the instruction in ID.
- id_rs_used  in  NUM_SRC  source actually read.
- id_rd  in  REG_ADDR_W  rd of the instruction in ID.
- id_wen  in  1  ID instruction writes rd.
- id_bypass_sel  out  NUM_SRC  1 = take WB data instead of regfile.
- idex_rd  in  REG_ADDR_W  rd of the instruction in EX.
- idex_wen  in  1  EX instruction writes rd.
- idex_is_load  in  1  EX instruction is a load.
- mc_issue_valid  in  1  multi-cycle op issue request.
- mc_issue_rd  in  REG_ADDR_W  its destination.
- mc_issue_ready  out  1  issue accepted this cycle if valid.
- mc_done_valid  in  1  multi-cycle unit wrote back.
- mc_done_rd  in  REG_ADDR_W  destination written.
- stall  out  1  hold PC and IF/ID; bubble ID/EX.
- pending_cnt  out  $clog2(MAX_OUTSTANDING+1)  in-flight count.
- mc_err  out  1  sticky protocol error.

Behaviour:
EX forwarding (combinational):
- For each source i, select the lowest stage k with stage_wen[k], stage_rd[k]!=0 and stage_rd[k]==ex_rs[i]; output ex_fwd_sel = k+1.
- The youngest stage has priority. If no stage matches, output 0.

ID bypass (combinational):
- id_bypass_sel[i]=1 when stage_wen[last] and stage_rd[last]!=0 and stage_rd[last]==id_rs[i].

Scoreboard (sequential):
- pending[31:1] register bit-vector; x0 is never pending.
- Issue handshake: the issue is accepted when mc_issue_valid && mc_issue_ready.
- mc_issue_ready = !stall && pending_cnt<MAX_OUTSTANDING && !pending[mc_issue_rd].
- An accepted issue sets pending[rd] on the next edge and increments the count. rd=0 is accepted without a pending bit or count change.
- mc_done_valid with pending[mc_done_rd]=1 clears the bit and decrements the count on the next edge.
- mc_done_valid with pending[mc_done_rd]=0, or with rd=0, changes no state and sets mc_err.
- Issue and done in the same cycle with the same rd cannot occur, because ready is low for that rd. With different rds, both apply and the count is unchanged.
- The stall, ready and done decisions use registered pending only. A done takes effect for stall in the following cycle.

Stall (combinational):
- Load-use: some i has id_rs_used[i], id_rs[i]!=0, idex_wen, idex_is_load and idex_rd==id_rs[i].
- RAW on a pending register: id_rs_used[i] && pending[id_rs[i]].
- WAW: id_wen && pending[id_rd].
- stall is the OR of these three conditions.

Reset:
- Clears pending, pending_cnt and mc_err.
- All outputs are combinational from inputs and cleared state, so stall=0 and mc_issue_ready=1 during reset.
- Reset mid-operation discards outstanding entries; the mul/div unit is reset by the same signal.

Optional Feature:
- Macro FWD_SCOREBOARD_PERF_EN.
- Defined: adds outputs stall_loaduse_cnt and stall_sb_cnt, 32 bits each. They count stall cycles caused by load-use and by scoreboard (RAW or WAW) respectively. When both causes are present, load-use is counted. Counters saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- rv32i_types gains fwd_sel_t (SEL_W-wide) and the constants FWD_SEL_NONE=0 and REG_X0=5'd0.
- Sub-module fwd_prio_match, one instance per source: it takes the rd/wen vectors and one rs, and returns the priority-encoded select. It is used for EX forwarding and, with a single stage, for the ID bypass.

Test Plan:
- EX/MEM and WB both write x5, EX rs1=x5 -> ex_fwd_sel[0]=1 (youngest); with only WB writing x5 -> sel=2 (NUM_FWD_STAGES=2).
- rd=x0 in every stage with wen=1, ex_rs=0 -> all sels 0; WB writes x7 and id_rs2=x7 -> id_bypass_sel[1]=1.
- Load in EX with rd=x3, ID uses rs1=x3 -> stall=1. Same case with id_rs_used[0]=0 -> stall=0.
- Issue div rd=x10, then ID reads x10 -> stall=1 from the cycle after issue; done rd=x10 -> stall=0 one cycle after done, pending_cnt 1->0.
- Issue four distinct rds -> pending_cnt=4 and mc_issue_ready=0 for a fifth; re-issue to a pending rd -> ready=0; ID with id_wen to a pending rd -> stall=1.
- mc_done_rd=x12 not pending -> mc_err=1 and held; assert rst low mid-operation -> pending_cnt=0, mc_err=0 and stall=0 immediately.
